// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The cache takes the slave modport; the fetcher/MemCtrl environment takes master.
interface icache_if #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
);
  logic                    fetch_en;
  logic [ADDR_W-1:0]       fetch_pc;
  logic                    fetch_valid;
  logic [31:0]             fetch_inst;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_pc;
  logic                    mem_done;
  logic [LINE_BYTES*8-1:0] mem_line;

  modport master (
    output fetch_en, fetch_pc, mem_done, mem_line,
    input  fetch_valid, fetch_inst, mem_en, mem_pc
  );

  modport slave (
    input  fetch_en, fetch_pc, mem_done, mem_line,
    output fetch_valid, fetch_inst, mem_en, mem_pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, full-line refill
// from MemCtrl on a miss, rollback cancels the response but not the fill.
module icache #(
  parameter int LINE_BYTES = 16,
  parameter int LINE_CNT   = 16,
  parameter int ADDR_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rollback,
  icache_if.slave    bus
);
  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int IDX_W     = $clog2(LINE_CNT);
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS     = LINE_BYTES / 4;
  localparam int WSEL_W    = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int LINE_BITS = LINE_BYTES * 8;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state;
  logic [LINE_CNT-1:0]   valid;
  logic                  drop;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WSEL_W-1:0]     req_sel;
  logic                  fetch_valid_q;
  logic [31:0]           fetch_inst_q;
  logic                  mem_en_q;
  logic [ADDR_W-1:0]     mem_pc_q;

  logic [LINE_BITS-1:0]  data_mem [LINE_CNT];
  logic [TAG_W-1:0]      tag_mem  [LINE_CNT];

  logic [TAG_W-1:0]      fetch_tag;
  logic [IDX_W-1:0]      fetch_idx;
  logic [WSEL_W-1:0]     fetch_sel;
  logic                  hit;
  logic                  fill;

  // With a single-word line the select field collapses to a constant zero.
  assign fetch_tag = bus.fetch_pc[ADDR_W-1 -: TAG_W];
  assign fetch_idx = bus.fetch_pc[OFF_W +: IDX_W];
  assign fetch_sel = bus.fetch_pc[2 +: WSEL_W] & WSEL_W'(WORDS - 1);
  assign hit       = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign fill      = rdy && (state == MISS) && bus.mem_done;

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_inst  = fetch_inst_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_pc      = mem_pc_q;

  // NOTE: data/tag arrays carry no reset; a cleared valid bit already hides stale contents.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[req_idx] <= bus.mem_line;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      drop          <= 1'b0;
      req_tag       <= '0;
      req_idx       <= '0;
      req_sel       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_pc_q      <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          fetch_valid_q <= 1'b0;
          if (!rollback && bus.fetch_en) begin
            if (hit) begin
              fetch_valid_q <= 1'b1;
              fetch_inst_q  <= data_mem[fetch_idx][32*fetch_sel +: 32];
            end else begin
              req_tag  <= fetch_tag;
              req_idx  <= fetch_idx;
              req_sel  <= fetch_sel;
              mem_en_q <= 1'b1;
              mem_pc_q <= {bus.fetch_pc[ADDR_W-1:OFF_W], OFF_W'(0)};
              drop     <= 1'b0;
              state    <= MISS;
            end
          end
        end
        MISS: begin
          // MemCtrl cannot abort a line, so rollback only suppresses the response.
          if (rollback) drop <= 1'b1;
          if (bus.mem_done) begin
            valid[req_idx] <= 1'b1;
            mem_en_q       <= 1'b0;
            fetch_valid_q  <= !(drop || rollback);
            fetch_inst_q   <= bus.mem_line[32*req_sel +: 32];
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetch traffic
// checked against a transparent-cache model over a synthetic backing memory.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  int   total = 0;
  int   bad   = 0;

  icache_if #(.LINE_BYTES(16), .ADDR_W(32)) bus ();

  icache #(.LINE_BYTES(16), .LINE_CNT(16), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: which line address each index holds, if any.
  bit          mv    [16];
  logic [31:0] mline [16];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_1004) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [127:0] build_line(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(la + 32'(4*w));
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one fetch and, on a predicted miss, serves the refill after lat wait
  // cycles; rollback is pulsed in wait cycle rb_at (rb_at == lat: with mem_done).
  task automatic fetch(input logic [31:0] pc, input int lat, input int rb_at, input string name);
    logic [31:0] la  = {pc[31:4], 4'h0};
    int          idx = int'(pc[7:4]);
    bit          exp_hit = mv[idx] && (mline[idx] == la);
    bit          dropped = 1'b0;
    bus.fetch_en = 1'b1;
    bus.fetch_pc = pc;
    tick();
    bus.fetch_en = 1'b0;
    if (exp_hit) begin
      total++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_inst !== mem_word(pc) || bus.mem_en !== 1'b0) begin
        bad++;
        $display("FAIL %s hit pc=%h: valid=%b inst=%h mem_en=%b, want valid=1 inst=%h mem_en=0",
                 name, pc, bus.fetch_valid, bus.fetch_inst, bus.mem_en, mem_word(pc));
      end
    end else begin
      total++;
      if (bus.mem_en !== 1'b1 || bus.mem_pc !== la || bus.fetch_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s miss_req pc=%h: mem_en=%b mem_pc=%h valid=%b, want mem_en=1 mem_pc=%h valid=0",
                 name, pc, bus.mem_en, bus.mem_pc, bus.fetch_valid, la);
      end
      for (int i = 0; i < lat; i++) begin
        rollback = (i == rb_at);
        if (i == rb_at) dropped = 1'b1;
        tick();
        rollback = 1'b0;
        total++;
        if (bus.mem_en !== 1'b1 || bus.mem_pc !== la || bus.fetch_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s miss_wait%0d: mem_en=%b mem_pc=%h valid=%b, want 1 %h 0",
                   name, i, bus.mem_en, bus.mem_pc, bus.fetch_valid, la);
        end
      end
      bus.mem_done = 1'b1;
      bus.mem_line = build_line(la);
      if (rb_at == lat) begin
        rollback = 1'b1;
        dropped  = 1'b1;
      end
      tick();
      bus.mem_done = 1'b0;
      rollback     = 1'b0;
      total++;
      if (bus.mem_en !== 1'b0 || bus.fetch_valid !== !dropped ||
          (!dropped && bus.fetch_inst !== mem_word(pc))) begin
        bad++;
        $display("FAIL %s fill pc=%h: mem_en=%b valid=%b inst=%h, want mem_en=0 valid=%b inst=%h",
                 name, pc, bus.mem_en, bus.fetch_valid, bus.fetch_inst, !dropped, mem_word(pc));
      end
      mv[idx]    = 1'b1;
      mline[idx] = la;
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_inst !== 32'h0 || bus.mem_en !== 1'b0 || bus.mem_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_init: valid=%b inst=%h mem_en=%b mem_pc=%h, want all 0",
               bus.fetch_valid, bus.fetch_inst, bus.mem_en, bus.mem_pc);
    end
    rst = 1'b0;
    tick();
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0000_0040;
    tick();
    bus.fetch_en = 1'b0;
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_pc !== 32'h0000_0040) begin
      bad++;
      $display("FAIL reset_premiss: mem_en=%b mem_pc=%h, want 1 00000040", bus.mem_en, bus.mem_pc);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (bus.fetch_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_async: valid=%b mem_en=%b mem_pc=%h, want 0 0 0",
               bus.fetch_valid, bus.mem_en, bus.mem_pc);
    end
    model_clear();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_resume: mem_en=%b, want 0", bus.mem_en);
    end
    fetch(32'h0000_0000, 1, -1, "reset_first_fetch");
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_1004, 2, -1, "cold_miss");
    tick();
    total++;
    if (bus.fetch_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL cold_pulse_end: valid=%b mem_en=%b, want 0 0", bus.fetch_valid, bus.mem_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [2];
    pcs[0] = 32'h0000_1008;
    pcs[1] = 32'h0000_100C;
    for (int i = 0; i < 2; i++) begin
      bus.fetch_en = 1'b1;
      bus.fetch_pc = pcs[i];
      tick();
      total++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_inst !== mem_word(pcs[i]) || bus.mem_en !== 1'b0) begin
        bad++;
        $display("FAIL b2b_hit%0d: valid=%b inst=%h mem_en=%b, want 1 %h 0",
                 i, bus.fetch_valid, bus.fetch_inst, bus.mem_en, mem_word(pcs[i]));
      end
    end
    bus.fetch_en = 1'b0;
    tick();
    total++;
    if (bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: valid=%b, want 0", bus.fetch_valid);
    end
  endtask

  task automatic test_conflict();
    fetch(32'h0000_1104, 1, -1, "conflict_evict");
    fetch(32'h0000_1004, 1, -1, "conflict_refetch");
  endtask

  task automatic test_rollback();
    fetch(32'h0000_2000, 3, 1, "rollback_miss");
    fetch(32'h0000_2000, 0, -1, "rollback_rehit");
  endtask

  task automatic test_stall();
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0000_3008;
    tick();
    bus.fetch_en = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.mem_en !== 1'b1 || bus.mem_pc !== 32'h0000_3000 || bus.fetch_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d: mem_en=%b mem_pc=%h valid=%b, want 1 00003000 0",
                 i, bus.mem_en, bus.mem_pc, bus.fetch_valid);
      end
    end
    rdy = 1'b1;
    bus.mem_done = 1'b1;
    bus.mem_line = build_line(32'h0000_3000);
    tick();
    bus.mem_done = 1'b0;
    total++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_inst !== mem_word(32'h0000_3008) || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL stall_resume: valid=%b inst=%h mem_en=%b, want 1 %h 0",
               bus.fetch_valid, bus.fetch_inst, bus.mem_en, mem_word(32'h0000_3008));
    end
    mv[0]    = 1'b1;
    mline[0] = 32'h0000_3000;
  endtask

  task automatic test_random();
    logic [23:0] tags [4];
    logic [31:0] pc;
    int          kind;
    tags[0] = 24'h10; tags[1] = 24'h11; tags[2] = 24'h20; tags[3] = 24'h33;
    for (int n = 0; n < 80; n++) begin
      pc   = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        rollback     = 1'b1;
        bus.fetch_en = 1'b1;
        bus.fetch_pc = pc;
        tick();
        rollback     = 1'b0;
        bus.fetch_en = 1'b0;
        total++;
        if (bus.fetch_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
          bad++;
          $display("FAIL rand_idle_rollback pc=%h: valid=%b mem_en=%b, want 0 0", pc, bus.fetch_valid, bus.mem_en);
        end
      end else if (kind == 1) begin
        bus.mem_done = 1'b1;
        bus.mem_line = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.mem_done = 1'b0;
        total++;
        if (bus.fetch_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
          bad++;
          $display("FAIL rand_stray_done: valid=%b mem_en=%b, want 0 0", bus.fetch_valid, bus.mem_en);
        end
      end else begin
        int lat = $urandom_range(0, 3);
        int rb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
        fetch(pc, lat, rb, "rand");
      end
    end
  endtask

  initial begin
    bus.fetch_en = 1'b0;
    bus.fetch_pc = '0;
    bus.mem_done = 1'b0;
    bus.mem_line = '0;
    model_clear();
    #2;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_rollback();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the instruction fetcher and `MemCtrl`. It answers fetch requests with a 32-bit instruction: in one cycle on a hit, or after a full-line refill from `MemCtrl` on a miss. A `rollback` during a refill cancels the fetcher response but still completes the fill. One outstanding miss at a time; the cache stalls new lookups while a miss is pending.

## Interface
- `LINE_BYTES`, 16: bytes per line; equals `ICACHE_LINE_SIZ`. Power of two, at least 4.
- `LINE_CNT`, 16: number of lines. Power of two.
- `ADDR_W`, 32: address width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable. When low, no state or output register updates.
- `rollback` in 1: pipeline flush from the ROB.
- `fetch_en` in 1: fetch request; sampled only in IDLE.
- `fetch_pc` in ADDR_W: request address, 4-byte aligned.
- `fetch_valid` out 1: one-cycle pulse; `fetch_inst` is valid.
- `fetch_inst` out 32: instruction word.
- `mem_en` out 1: line-refill request to `MemCtrl`.
- `mem_pc` out ADDR_W: line-aligned refill address.
- `mem_done` in 1: one-cycle pulse; `mem_line` is valid.
- `mem_line` in LINE_BYTES*8: refilled line. Byte i is at bits [8i+7:8i] (little-endian).

## Operation
- Address split:
  - offset = pc[log2(LINE_BYTES)-1:0]
  - index = next log2(LINE_CNT) bits
  - tag = remaining upper bits
  - word select = offset[.. :2]
  - With defaults: tag pc[31:8], index pc[7:4], word pc[3:2].
- Storage: data array, tag array, and a LINE_CNT-bit valid vector. Only the valid vector is reset.
- Hit: valid[index] && tag match. `fetch_inst` = line[word*32 +: 32].
- State IDLE (reset state):
  - If `rollback`: no action, and `fetch_valid` stays 0. `rollback` has priority over `fetch_en`.
  - Else if `fetch_en` and hit: `fetch_valid` <= 1 and `fetch_inst` <= selected word. Stay in IDLE.
  - Else if `fetch_en` and miss:
    - capture `fetch_pc` to `req_pc`
    - `mem_en` <= 1
    - `mem_pc` <= `fetch_pc` with offset bits cleared
    - clear the `drop` flag
    - go to MISS.
  - Otherwise `fetch_valid` <= 0.
- State MISS:
  - `fetch_en` is ignored. The fetcher holds its request or re-issues it after rollback.
  - `rollback` sets `drop` <= 1. `mem_en` stays asserted, because `MemCtrl` does not abort an in-flight line.
  - On `mem_done`:
    - write `mem_line` and the tag at `req_pc`'s index; set valid[index]
    - `mem_en` <= 0
    - `fetch_valid` <= !(`drop` || `rollback`); `fetch_inst` <= word of `mem_line` selected by `req_pc`
    - go to IDLE.
- `mem_done` outside MISS is ignored.
- Invariants:
  - `mem_pc` is held stable while `mem_en` = 1.
  - `mem_en` is never reasserted in the cycle after `mem_done`, which gives `MemCtrl` its IDLE clear cycle.
- `rdy` = 0: state, arrays, and all outputs hold their current values. The consumer also gates on `rdy`.

## Timing
- Reset values (asynchronous, while `rst` is high):
  - state IDLE, valid vector 0
  - `fetch_valid` 0, `fetch_inst` 0
  - `mem_en` 0, `mem_pc` 0
  - `drop` 0.
- Hit latency: request sampled at edge N gives `fetch_valid` high during cycle N..N+1. Throughput is one hit per cycle for back-to-back requests.
- Miss latency:
  - `mem_en` rises at edge N.
  - `fetch_valid` rises at the edge after `mem_done` is sampled.
  - The next lookup can be sampled at the edge after that.
  - The refilled line is immediately hittable.
- `rst` asserted mid-miss: abandon the fill and clear all valid bits. An outstanding `MemCtrl` transfer is reset by the same `rst`.
- A refill to an index holding another tag overwrites that line (conflict eviction).

## Test plan
- **Reset:** assert `rst` mid-cycle → `fetch_valid`, `mem_en` and `mem_pc` go to 0 immediately; the first fetch to 0x0 misses.
- **Cold miss:** `fetch_pc`=0x1004; respond `mem_done` with a line whose word1 = 0x00500093 → `mem_pc`=0x1000, `mem_en` drops after `mem_done`, then one `fetch_valid` pulse with `fetch_inst`=0x00500093.
- **Hits:** after the cold miss, back-to-back fetches to 0x1008 and 0x100C → `fetch_valid` on two consecutive cycles with words 2 and 3, `mem_en` stays 0.
- **Conflict:** fetch 0x1104 (same index 0, tag 0x11) → miss with `mem_pc`=0x1100; a later fetch to 0x1004 misses again.
- **Rollback mid-miss:** fetch 0x2000, pulse `rollback` two cycles later, then deliver `mem_done` → no `fetch_valid`, line filled; the next fetch to 0x2000 hits in one cycle.
- **Stall:** hold `rdy`=0 for 3 cycles while in MISS with `mem_done` low → `mem_en`, `mem_pc` and state are unchanged; after `rdy`=1 and `mem_done`, the normal response follows.
